// File: rtl/pc_sequencer.sv
// Program-counter and return-address sequencer.
//
// Holds the fetch PC and a hardware call/return stack, resolves the per-cycle flow
// decisions (ret/reti, jump, branch, sequential) and takes interrupt entry/exit.
//
// Ports:
//   clk, reset_n        core clock, asynchronous active-low reset
//   stall               hold all state; decision inputs ignored
//   jump/branch         absolute / relative redirect (jump wins)
//   call                with jump: push return address (pc+1)
//   ret/reti            pop stack and redirect; reti also clears int_active
//   target, offset      jump/call address, signed branch displacement
//   interrupt_req/_vector  level request and handler address
//   pc                  registered fetch address
//   flush               high the cycle after a taken redirect
//   int_ack             one-cycle pulse on interrupt entry
//   int_active          handler in progress, masks further entry
//   depth               return-stack occupancy 0..CALL_DEPTH
//   stack_fault         sticky overflow/underflow flag
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH     = 16,
  parameter int unsigned          CALL_DEPTH   = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          stall,
  input  logic                          jump,
  input  logic                          branch,
  input  logic                          call,
  input  logic                          ret,
  input  logic                          reti,
  input  logic [PC_WIDTH-1:0]           target,
  input  logic [PC_WIDTH-1:0]           offset,
  input  logic                          interrupt_req,
  input  logic [PC_WIDTH-1:0]           interrupt_vector,
  output logic [PC_WIDTH-1:0]           pc,
  output logic                          flush,
  output logic                          int_ack,
  output logic                          int_active,
  output logic [$clog2(CALL_DEPTH):0]   depth,
  output logic                          stack_fault
);

  localparam int unsigned DW = $clog2(CALL_DEPTH);
  localparam logic [DW:0]         DepthFull = CALL_DEPTH;
  localparam logic [DW:0]         DepthOne  = 1;
  localparam logic [PC_WIDTH-1:0] PcOne     = 1;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                flush_q, flush_d;
  logic                int_ack_q, int_ack_d;
  logic                int_active_q, int_active_d;
  logic [DW:0]         depth_q, depth_d;
  logic                stack_fault_q, stack_fault_d;

  logic [PC_WIDTH-1:0] stack_q [CALL_DEPTH];
  logic                stack_we;
  logic [DW-1:0]       stack_widx;
  logic [PC_WIDTH-1:0] stack_wdata;

  logic [PC_WIDTH-1:0] seq, flow_tgt;
  logic [DW-1:0]       top_idx, push_idx;
  logic                pop_req, can_pop, do_pop, redirect;

  always_comb begin
    seq      = pc_q + PcOne;
    pop_req  = ret | reti;
    can_pop  = (depth_q != '0);
    do_pop   = pop_req & can_pop;
    top_idx  = DW'(depth_q - DepthOne);
    push_idx = DW'(depth_q);

    // Flow target ignoring interrupts; an underflowing pop falls through to seq.
    flow_tgt = seq;
    redirect = 1'b0;
    if (pop_req) begin
      if (can_pop) begin
        flow_tgt = stack_q[top_idx];
        redirect = 1'b1;
      end
    end else if (jump) begin
      flow_tgt = target;
      redirect = 1'b1;
    end else if (branch) begin
      flow_tgt = pc_q + offset;
      redirect = 1'b1;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    flush_d       = 1'b0;
    int_ack_d     = 1'b0;
    int_active_d  = int_active_q;
    depth_d       = depth_q;
    stack_fault_d = stack_fault_q;
    stack_we      = 1'b0;
    stack_widx    = push_idx;
    stack_wdata   = seq;

    if (!stall) begin
      if (pop_req && !can_pop) stack_fault_d = 1'b1;

      if (interrupt_req && !int_active_q) begin
        pc_d         = interrupt_vector;
        flush_d      = 1'b1;
        int_ack_d    = 1'b1;
        int_active_d = 1'b1;
        stack_wdata  = flow_tgt;
        if (do_pop) begin
          // Pop and push in the same cycle: overwrite the top, depth unchanged.
          stack_we   = 1'b1;
          stack_widx = top_idx;
        end else if (depth_q == DepthFull) begin
          stack_fault_d = 1'b1;
        end else begin
          stack_we = 1'b1;
          depth_d  = depth_q + DepthOne;
        end
      end else begin
        pc_d    = flow_tgt;
        flush_d = redirect;
        if (reti) int_active_d = 1'b0;
        if (do_pop) begin
          depth_d = depth_q - DepthOne;
        end else if (jump && call && !pop_req) begin
          if (depth_q == DepthFull) begin
            stack_fault_d = 1'b1;
          end else begin
            stack_we = 1'b1;
            depth_d  = depth_q + DepthOne;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_VECTOR;
      flush_q       <= 1'b0;
      int_ack_q     <= 1'b0;
      int_active_q  <= 1'b0;
      depth_q       <= '0;
      stack_fault_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      int_ack_q     <= int_ack_d;
      int_active_q  <= int_active_d;
      depth_q       <= depth_d;
      stack_fault_q <= stack_fault_d;
    end
  end

  // Stack storage needs no reset; occupancy is tracked by depth_q.
  always_ff @(posedge clk) begin
    if (stack_we) stack_q[stack_widx] <= stack_wdata;
  end

  assign pc          = pc_q;
  assign flush       = flush_q;
  assign int_ack     = int_ack_q;
  assign int_active  = int_active_q;
  assign depth       = depth_q;
  assign stack_fault = stack_fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, jump, branch, call, ret, reti, interrupt_req;
  logic [15:0] target, offset, interrupt_vector;
  logic [15:0] pc;
  logic        flush, int_ack, int_active, stack_fault;
  logic [3:0]  depth;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .jump             (jump),
    .branch           (branch),
    .call             (call),
    .ret              (ret),
    .reti             (reti),
    .target           (target),
    .offset           (offset),
    .interrupt_req    (interrupt_req),
    .interrupt_vector (interrupt_vector),
    .pc               (pc),
    .flush            (flush),
    .int_ack          (int_ack),
    .int_active       (int_active),
    .depth            (depth),
    .stack_fault      (stack_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    stall = 0; jump = 0; branch = 0; call = 0; ret = 0; reti = 0;
    interrupt_req = 0; target = 0; offset = 0;
  endtask

  // Advance one clock edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    interrupt_vector = 16'h0100;
    clr();
    reset_n = 0;
    #2;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_depth", depth, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ack", int_ack, 0);
    chk("rst_active", int_active, 0);
    chk("rst_fault", stack_fault, 0);
    reset_n = 1;

    // Sequential advance
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_pc", pc, i);
      chk("seq_flush", flush, 0);
      chk("seq_depth", depth, 0);
    end

    // Call / return
    jump = 1; target = 16'h0010; step(); clr();
    chk("jmp_pc", pc, 16'h0010);
    chk("jmp_flush", flush, 1);
    jump = 1; call = 1; target = 16'h0200; step(); clr();
    chk("call_pc", pc, 16'h0200);
    chk("call_flush", flush, 1);
    chk("call_depth", depth, 1);
    ret = 1; step(); clr();
    chk("ret_pc", pc, 16'h0011);
    chk("ret_flush", flush, 1);
    chk("ret_depth", depth, 0);
    step();
    chk("post_ret_flush", flush, 0);
    chk("post_ret_pc", pc, 16'h0012);

    // Negative branch and wrap
    jump = 1; target = 16'h0005; step(); clr();
    branch = 1; offset = 16'hFFFB; step(); clr();
    chk("bneg_pc", pc, 16'h0000);
    chk("bneg_flush", flush, 1);
    jump = 1; target = 16'hFFFF; step(); clr();
    step();
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_flush", flush, 0);

    // jump beats branch
    jump = 1; branch = 1; target = 16'h0500; offset = 16'h0003; step(); clr();
    chk("jb_pc", pc, 16'h0500);
    jump = 1; target = 16'h0000; step(); clr();

    // Nine calls overflow an 8-deep stack
    for (int k = 1; k <= 9; k++) begin
      jump = 1; call = 1; target = 16'h1000 + 16'(k * 16); step(); clr();
      chk("ncall_pc", pc, 16'h1000 + k * 16);
      chk("ncall_depth", depth, (k > 8) ? 8 : k);
      chk("ncall_fault", stack_fault, (k > 8) ? 1 : 0);
    end
    for (int j = 1; j <= 8; j++) begin
      ret = 1; step(); clr();
      chk("nret_pc", pc, (j <= 7) ? (16'h1001 + (8 - j) * 16) : 16'h0001);
      chk("nret_depth", depth, 8 - j);
    end
    ret = 1; step(); clr();
    chk("under_pc", pc, 16'h0002);
    chk("under_flush", flush, 0);
    chk("under_depth", depth, 0);
    chk("under_fault", stack_fault, 1);

    // Interrupt overrides a taken branch
    jump = 1; target = 16'h0040; step(); clr();
    branch = 1; offset = 16'h0008; interrupt_req = 1; step(); clr();
    chk("irq_pc", pc, 16'h0100);
    chk("irq_ack", int_ack, 1);
    chk("irq_active", int_active, 1);
    chk("irq_flush", flush, 1);
    chk("irq_depth", depth, 1);
    interrupt_req = 1; step(); clr();
    chk("irq2_pc", pc, 16'h0101);
    chk("irq2_ack", int_ack, 0);
    chk("irq2_depth", depth, 1);
    reti = 1; step(); clr();
    chk("reti_pc", pc, 16'h0048);
    chk("reti_active", int_active, 0);
    chk("reti_depth", depth, 0);

    // Interrupt held off by stall
    for (int s = 0; s < 3; s++) begin
      stall = 1; interrupt_req = 1; jump = 1; target = 16'h0777; step();
      chk("stall_pc", pc, 16'h0048);
      chk("stall_ack", int_ack, 0);
      chk("stall_flush", flush, 0);
      chk("stall_active", int_active, 0);
    end
    clr();
    interrupt_req = 1; step(); clr();
    chk("unstall_pc", pc, 16'h0100);
    chk("unstall_ack", int_ack, 1);
    chk("unstall_depth", depth, 1);
    reti = 1; interrupt_req = 1; step(); clr();
    chk("reti_masked_pc", pc, 16'h0049);
    chk("reti_masked_active", int_active, 0);

    // Return and interrupt in the same cycle
    jump = 1; call = 1; target = 16'h0300; step(); clr();
    chk("c2_depth", depth, 1);
    ret = 1; interrupt_req = 1; step(); clr();
    chk("retirq_pc", pc, 16'h0100);
    chk("retirq_depth", depth, 1);
    chk("retirq_active", int_active, 1);
    reti = 1; step(); clr();
    chk("retirq_back_pc", pc, 16'h004A);
    chk("retirq_back_depth", depth, 0);

    // Asynchronous reset mid-operation
    jump = 1; call = 1; target = 16'h0ABC; step(); clr();
    #2 reset_n = 0;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_depth", depth, 0);
    chk("arst_fault", stack_fault, 0);
    chk("arst_flush", flush, 0);
    #3 reset_n = 1;
    step();
    chk("arst_seq_pc", pc, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
